// File: rtl/ir_nec_pkg.sv
// Shared NEC IR definitions: one-hot FSM states, default 50 MHz timing and frame layout.
// Used by ir_encoder_nec and ir_carrier_gen.
package ir_nec_pkg;

  typedef enum logic [5:0] {
    IDLE       = 6'b000001,
    HEAD_MARK  = 6'b000010,
    HEAD_SPACE = 6'b000100,
    BIT_MARK   = 6'b001000,
    BIT_SPACE  = 6'b010000,
    STOP_MARK  = 6'b100000
  } nec_state_t;

  // Nominal segment lengths; the decoder builds its acceptance windows around these.
  localparam int NEC_T_HEAD_MARK  = 450000;
  localparam int NEC_T_HEAD_SPACE = 225000;
  localparam int NEC_T_BIT_MARK   = 28000;
  localparam int NEC_T_ZERO_SPACE = 28000;
  localparam int NEC_T_ONE_SPACE  = 84500;
  localparam int NEC_CARRIER_HALF = 658;

  localparam int NEC_FRAME_W = 32;
  localparam int NEC_SPLIT   = 16;
  localparam int NEC_CNT_W   = 19;
  localparam int NEC_BIT_W   = 5;

endpackage

// File: rtl/ir_carrier_gen.sv
// Carrier divider: toggles every HALF cycles while enabled; restart forces the
// counter to 0 and the carrier high. carrier_nxt is the value it takes at the next edge.
module ir_carrier_gen
  import ir_nec_pkg::*;
#(
  parameter int HALF = NEC_CARRIER_HALF
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic restart,
  output logic carrier_nxt
);

  localparam int CW = (HALF > 1) ? $clog2(HALF) : 1;

  logic [CW-1:0] cnt, cnt_nxt;
  logic          carrier;

  always_comb begin
    cnt_nxt     = cnt;
    carrier_nxt = carrier;
    if (restart) begin
      cnt_nxt     = '0;
      carrier_nxt = 1'b1;
    end else if (en) begin
      if (cnt == CW'(HALF - 1)) begin
        cnt_nxt     = '0;
        carrier_nxt = ~carrier;
      end else begin
        cnt_nxt = cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt     <= '0;
      carrier <= 1'b0;
    end else begin
      cnt     <= cnt_nxt;
      carrier <= carrier_nxt;
    end
  end

endmodule

// File: rtl/ir_encoder_nec.sv
// NEC IR frame transmitter: header mark/space, 32 pulse-distance bits LSB first, stop mark.
// Optional carrier-modulated LED output when IR_CARRIER_EN is defined.
module ir_encoder_nec
  import ir_nec_pkg::*;
#(
`ifdef IR_CARRIER_EN
  parameter int CARRIER_HALF = NEC_CARRIER_HALF,
`endif
  parameter int T_HEAD_MARK  = NEC_T_HEAD_MARK,
  parameter int T_HEAD_SPACE = NEC_T_HEAD_SPACE,
  parameter int T_BIT_MARK   = NEC_T_BIT_MARK,
  parameter int T_ZERO_SPACE = NEC_T_ZERO_SPACE,
  parameter int T_ONE_SPACE  = NEC_T_ONE_SPACE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [NEC_SPLIT-1:0]  iraddr,
  input  logic [NEC_SPLIT-1:0]  irdata,
  output logic                  busy,
  output logic                  done,
  output logic                  oir,
  output logic [5:0]            dbg_state
`ifdef IR_CARRIER_EN
  ,
  output logic                  oled
`endif
);

  // Handshake: start is sampled only while idle (busy=0); the request is taken on
  // that edge, busy rises the next cycle, and starts seen while busy=1 are dropped.

  localparam logic [NEC_CNT_W-1:0] L_HM = NEC_CNT_W'(T_HEAD_MARK - 1);
  localparam logic [NEC_CNT_W-1:0] L_HS = NEC_CNT_W'(T_HEAD_SPACE - 1);
  localparam logic [NEC_CNT_W-1:0] L_BM = NEC_CNT_W'(T_BIT_MARK - 1);
  localparam logic [NEC_CNT_W-1:0] L_ZS = NEC_CNT_W'(T_ZERO_SPACE - 1);
  localparam logic [NEC_CNT_W-1:0] L_OS = NEC_CNT_W'(T_ONE_SPACE - 1);

  nec_state_t                 state;
  logic [NEC_CNT_W-1:0]       cnt;
  logic [NEC_BIT_W-1:0]       bit_cnt;
  logic [NEC_FRAME_W-1:0]     shift;
  logic [NEC_CNT_W-1:0]       seg_last;
  logic                       seg_end;

  assign dbg_state = state;

  // Last count of the current segment; the space length depends on the bit being sent.
  always_comb begin
    seg_last = '0;
    case (state)
      HEAD_MARK:           seg_last = L_HM;
      HEAD_SPACE:          seg_last = L_HS;
      BIT_MARK, STOP_MARK: seg_last = L_BM;
      BIT_SPACE:           seg_last = shift[0] ? L_OS : L_ZS;
      default:             seg_last = '0;
    endcase
  end

  assign seg_end = (cnt == seg_last);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      oir     <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
      cnt     <= '0;
      bit_cnt <= '0;
      shift   <= '0;
    end else begin
      done <= 1'b0;
      cnt  <= cnt + 1'b1;
      case (state)
        IDLE: begin
          oir  <= 1'b1;
          busy <= 1'b0;
          cnt  <= '0;
          if (start) begin
            shift <= {irdata, iraddr};
            state <= HEAD_MARK;
            oir   <= 1'b0;
            busy  <= 1'b1;
          end
        end
        HEAD_MARK: if (seg_end) begin
          state <= HEAD_SPACE;
          oir   <= 1'b1;
          cnt   <= '0;
        end
        HEAD_SPACE: if (seg_end) begin
          state <= BIT_MARK;
          oir   <= 1'b0;
          cnt   <= '0;
        end
        BIT_MARK: if (seg_end) begin
          state <= BIT_SPACE;
          oir   <= 1'b1;
          cnt   <= '0;
        end
        BIT_SPACE: if (seg_end) begin
          shift   <= shift >> 1;
          bit_cnt <= bit_cnt + 1'b1;
          oir     <= 1'b0;
          cnt     <= '0;
          state   <= (bit_cnt == NEC_BIT_W'(NEC_FRAME_W - 1)) ? STOP_MARK : BIT_MARK;
        end
        STOP_MARK: if (seg_end) begin
          state <= IDLE;
          oir   <= 1'b1;
          busy  <= 1'b0;
          done  <= 1'b1;
          cnt   <= '0;
        end
        default: begin
          state <= IDLE;
          oir   <= 1'b1;
          busy  <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef IR_CARRIER_EN
  logic mark_start, mark_nxt, carrier_nxt;

  // A mark begins on the edge that drives oir low; the divider restarts there.
  assign mark_start = ((state == IDLE) && start) ||
                      (((state == HEAD_SPACE) || (state == BIT_SPACE)) && seg_end);
  assign mark_nxt   = mark_start ||
                      (((state == HEAD_MARK) || (state == BIT_MARK) ||
                        (state == STOP_MARK)) && !seg_end);

  ir_carrier_gen #(.HALF(CARRIER_HALF)) u_carrier (
    .clk         (clk),
    .rst         (rst),
    .en          (1'b1),
    .restart     (mark_start),
    .carrier_nxt (carrier_nxt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) oled <= 1'b0;
    else     oled <= carrier_nxt & mark_nxt;
  end
`endif

endmodule

// File: tb/tb_ir_encoder_nec.sv
// Directed bench for ir_encoder_nec with shortened segment timing: measures every
// oir run of each frame and checks it against a waveform model built from the sent word.
module tb_ir_encoder_nec;

  localparam int HM = 20;
  localparam int HS = 10;
  localparam int BM = 3;
  localparam int ZS = 3;
  localparam int OS = 7;

  localparam logic [5:0] ST_IDLE      = 6'b000001;
  localparam logic [5:0] ST_HEAD_MARK = 6'b000010;
  localparam logic [5:0] ST_BIT_MARK  = 6'b001000;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] iraddr, irdata;
  logic        busy, done, oir;
  logic [5:0]  dbg_state;
`ifdef IR_CARRIER_EN
  logic        oled;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ir_encoder_nec #(
    .T_HEAD_MARK (HM),
    .T_HEAD_SPACE(HS),
    .T_BIT_MARK  (BM),
    .T_ZERO_SPACE(ZS),
    .T_ONE_SPACE (OS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .iraddr   (iraddr),
    .irdata   (irdata),
    .busy     (busy),
    .done     (done),
    .oir      (oir),
    .dbg_state(dbg_state)
`ifdef IR_CARRIER_EN
    ,
    .oled     (oled)
`endif
  );

  typedef struct {
    logic [15:0] addr;
    logic [15:0] data;
    int          exp_len;
    int          inj1;
    int          inj2;
    bit          chain;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_seg_len(input logic [31:0] w, input int k);
    if (k == 0) return HM;
    if (k == 1) return HS;
    if (k % 2 == 0) return BM;
    return w[(k - 3) / 2] ? OS : ZS;
  endfunction

  // Called at a negedge: raise start for one cycle, then verify the mark began.
  task automatic pulse_start(input logic [15:0] a, input logic [15:0] d);
    iraddr = a;
    irdata = d;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_latency_oir", oir, 1'b0);
    check("start_latency_busy", busy, 1'b1);
    check("start_state", dbg_state, ST_HEAD_MARK);
  endtask

  task automatic capture(input logic [31:0] word, input int exp_len, input int inj1,
                         input int inj2, input bit chain, input logic [15:0] ca,
                         input logic [15:0] cd);
    int          lens[$];
    bit          lvls[$];
    int          cur_len, frame_len, errs, early_dones;
    bit          cur;
    logic [31:0] dec;
    cur = oir; cur_len = 1; frame_len = 1; errs = 0; early_dones = 0; dec = '0;
    for (int cyc = 1; cyc < 2000; cyc++) begin
      if (cyc == inj1 || cyc == inj2) begin
        start  = 1'b1;
        iraddr = 16'($urandom);
        irdata = 16'($urandom);
      end
      @(negedge clk);
      start = 1'b0;
      if (!busy) break;
      if (done) early_dones++;
      frame_len++;
      if (oir == cur) cur_len++;
      else begin
        lens.push_back(cur_len); lvls.push_back(cur);
        cur = oir; cur_len = 1;
      end
    end
    lens.push_back(cur_len); lvls.push_back(cur);
    check("frame_end_busy", busy, 1'b0);
    check("done_at_busy_fall", done, 1'b1);
    check("idle_oir", oir, 1'b1);
    check("spurious_done", early_dones, 0);
    check("frame_len", frame_len, exp_len);
    check("seg_count", lens.size(), 67);
    for (int k = 0; k < lens.size() && k < 67; k++) begin
      if (lens[k] != exp_seg_len(word, k)) errs++;
      if (lvls[k] != ((k == 0 || k % 2 == 0) ? 1'b0 : 1'b1)) errs++;
    end
    check("seg_timing_errors", errs, 0);
    for (int b = 0; b < 32; b++)
      if (3 + 2 * b < lens.size() && lens[3 + 2 * b] == OS) dec[b] = 1'b1;
    check("decoded_word", dec, word);
    if (chain) begin
      pulse_start(ca, cd);
    end else begin
      @(negedge clk);
      check("done_one_cycle", done, 1'b0);
      check("post_idle_oir", oir, 1'b1);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'h00FF, 16'hB847, 289, 0, 0, 1'b0};
    vecs[1] = '{16'h1234, 16'hABCD, 285, 0, 0, 1'b0};
    vecs[2] = '{16'h0000, 16'h0000, 225, 0, 0, 1'b1};
    vecs[3] = '{16'hFFFF, 16'hFFFF, 353, 0, 0, 1'b0};
    vecs[4] = '{16'h00FF, 16'hB847, 289, 25, 198, 1'b0};

    rst = 1'b1; start = 1'b0; iraddr = '0; irdata = '0;
    repeat (3) @(negedge clk);
    check("reset_oir", oir, 1'b1);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_state", dbg_state, ST_IDLE);
    rst = 1'b0;
    @(negedge clk);
    check("idle_after_reset", oir, 1'b1);

    for (int i = 0; i < 5; i++) begin
      logic [15:0] na, nd;
      na = (i < 4) ? vecs[i + 1].addr : 16'h0;
      nd = (i < 4) ? vecs[i + 1].data : 16'h0;
      if (i == 0 || !vecs[i - 1].chain) pulse_start(vecs[i].addr, vecs[i].data);
      capture({vecs[i].data, vecs[i].addr}, vecs[i].exp_len, vecs[i].inj1, vecs[i].inj2,
              vecs[i].chain, na, nd);
    end

    // Abandon a frame during the mark of bit 10 (all-zero word: bit k mark at 30+6k).
    pulse_start(16'h0000, 16'h0000);
    repeat (91) @(negedge clk);
    check("pre_reset_oir", oir, 1'b0);
    check("pre_reset_state", dbg_state, ST_BIT_MARK);
    #2 rst = 1'b1;
    #1;
    check("async_reset_oir", oir, 1'b1);
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_state", dbg_state, ST_IDLE);
    check("async_reset_done", done, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check("reset_hold_done", done, 1'b0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("after_reset_done", done, 1'b0);
    check("after_reset_oir", oir, 1'b1);
    pulse_start(16'h1234, 16'hABCD);
    capture(32'hABCD1234, 285, 0, 0, 1'b0, 16'h0, 16'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
